piano_key_scanner: RTL
======================

// Module: piano_key_scanner
// PURPOSE
//  Scans the 3x3 piano key matrix (7 note keys + octave up/down) and debounces every key.
//  Drives clean, registered level signals c,d,e,f,g,a,b,up,down to the note/octave consumers
//  (7-segment note display, tone generator). Note outputs are priority-encoded, at most one high.
//  Emits a one-cycle strobe on each new note press.
// PARAMETERS
//  SCAN_DIV    1000  clock cycles each row is driven; 2..65535
//  DEB_FRAMES  4     consecutive full scan frames a key must differ from its stable state before it flips; 1..15
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  rst_n        in   1  synchronous reset, active-low
//  col_n        in   3  matrix column sense, active-low (pulled up; 0 = key closed)
//  row_n        out  3  matrix row drive, active-low, exactly one bit low at all times
//  c,d,e,f,g,a,b out 1  debounced, priority-encoded note levels
//  up, down     out  1  debounced octave modifier levels
//  note_strobe  out  1  one-cycle pulse when the encoded note changes to a new non-zero note
// BEHAVIOUR
//  Key map (row,col): r0:{c,d,e} r1:{f,g,a} r2:{b,up,down}; col index 0,1,2 in that order.
//  Reset (rst_n=0 at clk edge): row_n=3'b110, div counter=0, raw/stable/deb counters=0,
//   all note/up/down outputs=0, note_strobe=0. Applies mid-scan/mid-debounce; no partial frame kept.
//  Scan FSM states ROW0->ROW1->ROW2->ROW0; row_n = 110/101/011 respectively.
//   div_cnt counts 0..SCAN_DIV-1 in each state; at div_cnt==SCAN_DIV-1: latch ~col_n into the
//   3 raw bits of the current row, clear div_cnt, advance state. Frame = 3*SCAN_DIV cycles.
//   frame_tick asserted internally on the cycle ROW2 samples.
//  Debounce (per key, evaluated only on frame_tick, using the raw bits incl. the just-sampled row):
//   raw==stable -> cnt=0; raw!=stable -> if cnt==DEB_FRAMES-1 {stable=raw; cnt=0} else cnt++.
//   Counters 4 bits, never wrap beyond DEB_FRAMES-1.
//  Encode (registered, updates cycle after frame_tick):
//   notes: highest-priority stable note only, priority c>d>e>f>g>a>b; others 0.
//   up/down: follow stable; if both stable pressed, both outputs 0.
//  note_strobe: 1 for exactly one cycle when the registered note vector changes and new value != 0
//   (press, or priority switch to another note). Release to all-zero gives no strobe.
//  Latency: key closed steadily from before a frame start -> output high
//   DEB_FRAMES frames (+ frame alignment <=1 frame) + 1 cycle after closure.
//  Glitch shorter than DEB_FRAMES frames: no output change, counter returns to 0.
//  Simultaneous press of several notes: lower-priority note appears when higher one is released
//   (after its own debounce), with note_strobe.
// TESTING (bench uses SCAN_DIV=4, DEB_FRAMES=2; frame=12 cycles)
//  Reset: hold rst_n=0 2 cycles -> row_n=110, all outputs 0; row_n then cycles 110,101,011 every 4 clk.
//  Press e (col_n[2]=0 while row_n=110) steady -> e=1 after 2 frames+1, one note_strobe pulse; release -> e=0 2 frames later, no strobe.
//  1-frame glitch on key a -> a stays 0, no strobe.
//  Hold c and g: c=1 only; release c -> c=0 and g=1 on same cycle, note_strobe pulses once.
//  Hold up+down -> up=0,down=0; release down -> up=1 after debounce.
//  Assert rst_n=0 mid-debounce of d (cnt=1) -> outputs 0, d re-debounces full 2 frames after release of reset.

Source files
------------

// File: rtl/piano_key_scanner.sv
// 3x3 piano key matrix scanner: row-multiplexed sampling, per-key frame debounce,
// priority-encoded note levels, octave modifiers and a new-note strobe.
module piano_key_scanner #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEB_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] col_n,
  output logic [2:0] row_n,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       a,
  output logic       b,
  output logic       up,
  output logic       down,
  output logic       note_strobe
);

  typedef enum logic [1:0] {ROW0, ROW1, ROW2} scan_state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB_LAST = 4'(DEB_FRAMES - 1);

  scan_state_t state, state_nxt;
  logic [15:0] div_cnt;
  logic        sample;
  logic        frame_tick;
  logic [8:0]  raw;
  logic [8:0]  raw_now;
  logic [8:0]  stable;
  logic [3:0]  cnt [9];
  logic [6:0]  notes, notes_nxt;
  logic [1:0]  updn, updn_nxt;
  logic        found;

  always_comb begin
    state_nxt  = state;
    row_n      = 3'b110;
    sample     = (div_cnt == DIV_LAST);
    frame_tick = 1'b0;
    case (state)
      ROW0: begin
        row_n = 3'b110;
        if (sample) state_nxt = ROW1;
      end
      ROW1: begin
        row_n = 3'b101;
        if (sample) state_nxt = ROW2;
      end
      ROW2: begin
        row_n      = 3'b011;
        frame_tick = sample;
        if (sample) state_nxt = ROW0;
      end
      default: state_nxt = ROW0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ROW0;
      div_cnt <= '0;
      raw     <= '0;
    end else begin
      state <= state_nxt;
      if (sample) begin
        div_cnt <= '0;
        case (state)
          ROW0:    raw[2:0] <= ~col_n;
          ROW1:    raw[5:3] <= ~col_n;
          ROW2:    raw[8:6] <= ~col_n;
          default: ;
        endcase
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

  // Debounce sees the row being latched this cycle, so a frame is judged on fresh data.
  always_comb begin
    raw_now = raw;
    if (state == ROW2) raw_now[8:6] = ~col_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable <= '0;
      for (int unsigned k = 0; k < 9; k++) cnt[k] <= '0;
    end else if (frame_tick) begin
      for (int unsigned k = 0; k < 9; k++) begin
        if (raw_now[k] == stable[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == DEB_LAST) begin
          stable[k] <= raw_now[k];
          cnt[k]    <= '0;
        end else begin
          cnt[k] <= cnt[k] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    notes_nxt = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < 7; k++) begin
      if (stable[k] && !found) begin
        notes_nxt[k] = 1'b1;
        found        = 1'b1;
      end
    end
    updn_nxt = (stable[7] && stable[8]) ? 2'b00 : stable[8:7];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      notes       <= '0;
      updn        <= '0;
      note_strobe <= 1'b0;
    end else begin
      notes       <= notes_nxt;
      updn        <= updn_nxt;
      note_strobe <= (notes_nxt != notes) && (notes_nxt != '0);
    end
  end

  assign {b, a, g, f, e, d, c} = notes;
  assign {down, up}            = updn;

endmodule
